pll_lock_mgr: RTL and testbench

//  Supervises the rPLL wrapper from the reference-clock side. Drives the PLL reset,

---
 rtl/pll_lock_mgr_pkg.sv | 31 +++
 rtl/pll_lock_sync.sv | 29 ++
 rtl/pll_lock_mgr.sv | 154 +++++++++++++++
 tb/tb_pll_lock_mgr.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_lock_mgr_pkg.sv
// pll_mgr_pkg: shared definitions for the PLL lock manager.
//   - state encoding for the acquisition FSM (PRST, WAIT, STAB, RUN, FAIL)
//   - cnt_width(): width of the shared cycle counter, sized so the largest
//     terminal count fits without wrapping.
// No ports; imported by pll_lock_mgr.
package pll_mgr_pkg;

  localparam logic [2:0] ST_PRST = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_STAB = 3'd2;
  localparam logic [2:0] ST_RUN  = 3'd3;
  localparam logic [2:0] ST_FAIL = 3'd4;

  typedef enum logic [2:0] {
    PRST = ST_PRST,
    WAIT = ST_WAIT,
    STAB = ST_STAB,
    RUN  = ST_RUN,
    FAIL = ST_FAIL
  } state_t;

  // $clog2(max(a,b,c)+1): one counter serves all three timed phases.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// pll_lock_sync: multi-flop synchroniser bringing the asynchronous PLL LOCK
// into the clkin domain. Output equals the input delayed by SYNC_STAGES flops.
// Ports:
//   clkin     in  reference clock
//   reset     in  synchronous active-high reset, clears the chain to 0
//   async_in  in  asynchronous level (PLL LOCK)
//   sync_out  out synchronised level
module pll_lock_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clkin,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clkin) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], async_in};
    end
  end

  assign sync_out = chain[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_mgr.sv
// pll_lock_mgr: supervises the PLL from the reference-clock side. Pulses the
// PLL reset, waits for a synchronised and qualified lock, retries on timeout,
// and releases sys_rst once lock has been stable. Runs entirely on clkin.
// Optional feature macro: PLL_LOSS_CNT_EN adds the lock_loss_cnt port/counter.
// Ports:
//   clkin          in   reference clock
//   reset          in   synchronous active-high reset
//   pll_lock       in   PLL LOCK, asynchronous to clkin
//   pll_reset      out  PLL RESET, active-high
//   sys_rst        out  downstream system reset, active-high
//   ready          out  1 while in RUN (locked and qualified)
//   fail           out  1 once retries are exhausted (left only by reset)
//   retry_cnt      out  retries in the current acquisition attempt
//   lock_loss_cnt  out  RUN->PRST events, saturating (PLL_LOSS_CNT_EN only)
module pll_lock_mgr
  import pll_mgr_pkg::*;
#(
  parameter int RST_PULSE_CYC    = 32,
  parameter int LOCK_TIMEOUT_CYC = 25000,
  parameter int STABLE_CYC       = 2500,
  parameter int SYNC_STAGES      = 2,
  parameter int MAX_RETRY        = 3
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt
`ifdef PLL_LOSS_CNT_EN
  ,
  output logic [7:0] lock_loss_cnt
`endif
);

  localparam int CW = cnt_width(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, STABLE_CYC);

  localparam logic [CW-1:0] RST_LAST = CW'(RST_PULSE_CYC - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [3:0]    MAX_R    = 4'(MAX_RETRY);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [3:0]    retry_nxt;
  logic          lock_s;

  pll_lock_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clkin   (clkin),
    .reset   (reset),
    .async_in(pll_lock),
    .sync_out(lock_s)
  );

  // Next-state logic. Every exit from a timed phase clears cnt, so the
  // counter only ever runs up to the terminal count of the current phase.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    retry_nxt = retry_cnt;
    case (state)
      PRST: begin
        if (cnt == RST_LAST) begin
          state_nxt = WAIT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      WAIT: begin
        if (lock_s) begin
          state_nxt = STAB;
          cnt_nxt   = '0;
        end else if (cnt == TMO_LAST) begin
          cnt_nxt = '0;
          if ((MAX_RETRY != 0) && (retry_cnt == MAX_R)) begin
            state_nxt = FAIL;
          end else begin
            state_nxt = PRST;
            if (retry_cnt != 4'hF) retry_nxt = retry_cnt + 4'd1;
          end
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      STAB: begin
        // A lock drop here is a glitch filter event, not a retry.
        if (!lock_s) begin
          state_nxt = WAIT;
          cnt_nxt   = '0;
        end else if (cnt == STB_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
          retry_nxt = 4'd0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      RUN: begin
        retry_nxt = 4'd0;
        cnt_nxt   = '0;
        if (!lock_s) state_nxt = PRST;
      end
      FAIL: begin
        cnt_nxt = '0;
      end
      default: begin
        state_nxt = PRST;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state     <= PRST;
      cnt       <= '0;
      retry_cnt <= 4'd0;
      pll_reset <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      retry_cnt <= retry_nxt;
      pll_reset <= (state_nxt == PRST) || (state_nxt == FAIL);
      sys_rst   <= (state_nxt != RUN);
      ready     <= (state_nxt == RUN);
      fail      <= (state_nxt == FAIL);
    end
  end

`ifdef PLL_LOSS_CNT_EN
  // Counts lock losses while running; only reset clears it.
  always_ff @(posedge clkin) begin
    if (reset) begin
      lock_loss_cnt <= 8'd0;
    end else if ((state == RUN) && (state_nxt == PRST) && (lock_loss_cnt != 8'hFF)) begin
      lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pll_lock_mgr.sv
// Self-checking bench for pll_lock_mgr (small parameter set). Stimulus pushes
// timed expectations into a queue; a negedge monitor checks each one on its
// cycle. The loss-counter scenario runs only with PLL_LOSS_CNT_EN defined.
module tb_pll_lock_mgr;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_lock;
  logic       pll_reset;
  logic       sys_rst;
  logic       ready;
  logic       fail;
  logic [3:0] retry_cnt;
`ifdef PLL_LOSS_CNT_EN
  logic [7:0] lock_loss_cnt;
`endif

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         cyc;
    string      nm;
    bit         chk_main;
    logic [7:0] main;
    bit         chk_llc;
    logic [7:0] llc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  pll_lock_mgr #(
    .RST_PULSE_CYC   (4),
    .LOCK_TIMEOUT_CYC(20),
    .STABLE_CYC      (8),
    .SYNC_STAGES     (2),
    .MAX_RETRY       (2)
  ) dut (
    .clkin    (clk),
    .reset    (reset),
    .pll_lock (pll_lock),
    .pll_reset(pll_reset),
    .sys_rst  (sys_rst),
    .ready    (ready),
    .fail     (fail),
    .retry_cnt(retry_cnt)
`ifdef PLL_LOSS_CNT_EN
    ,
    .lock_loss_cnt(lock_loss_cnt)
`endif
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_sorted(input exp_t e);
    int idx;
    idx = q.size();
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].cyc > e.cyc) begin
        idx = i;
        break;
      end
    end
    q.insert(idx, e);
  endtask

  // main = {pll_reset, sys_rst, ready, fail, retry_cnt}
  task automatic expect_at(input int c, input string nm, input logic pr, input logic sr,
                           input logic rd, input logic fl, input logic [3:0] rc);
    exp_t e;
    e.cyc = c; e.nm = nm; e.chk_main = 1'b1; e.main = {pr, sr, rd, fl, rc};
    e.chk_llc = 1'b0; e.llc = 8'd0;
    push_sorted(e);
  endtask

  task automatic expect_llc(input int c, input string nm, input logic [7:0] v);
    exp_t e;
    e.cyc = c; e.nm = nm; e.chk_main = 1'b0; e.main = 8'd0;
    e.chk_llc = 1'b1; e.llc = v;
    push_sorted(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds reset across two edges; r returns the last edge with reset applied.
  task automatic do_reset(input string nm, output int r);
    reset    = 1'b1;
    pll_lock = 1'b0;
    expect_at(cyc + 1, nm, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
`ifdef PLL_LOSS_CNT_EN
    expect_llc(cyc + 1, {nm, "_llc"}, 8'd0);
`endif
    tick(2);
    reset = 1'b0;
    r = cyc;
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      mon_e = q.pop_front();
      n_tests++;
      if (mon_e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: check for cycle %0d missed, now cycle %0d", mon_e.nm, mon_e.cyc, cyc);
      end else begin
        if (mon_e.chk_main &&
            ({pll_reset, sys_rst, ready, fail, retry_cnt} !== mon_e.main)) begin
          n_fail++;
          $display("FAIL %s @%0d: {pll_reset,sys_rst,ready,fail,retry_cnt} got %b_%b_%b_%b_%0d want %b_%b_%b_%b_%0d",
                   mon_e.nm, cyc, pll_reset, sys_rst, ready, fail, retry_cnt,
                   mon_e.main[7], mon_e.main[6], mon_e.main[5], mon_e.main[4], mon_e.main[3:0]);
        end
`ifdef PLL_LOSS_CNT_EN
        if (mon_e.chk_llc && (lock_loss_cnt !== mon_e.llc)) begin
          n_fail++;
          $display("FAIL %s @%0d: lock_loss_cnt got %0d want %0d", mon_e.nm, cyc, lock_loss_cnt, mon_e.llc);
        end
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, r2, r3, w, m, m2, b, w3, m3, m4;
    reset    = 1'b1;
    pll_lock = 1'b0;
    tick(1);

    // Scenario 1: first acquisition, lock rises 6 cycles into WAIT.
    do_reset("t1_reset_vals", r);
    w = r + 4;
    m = w + 6;
    expect_at(r + 3,  "t1_prst_last", 1, 1, 0, 0, 0);
    expect_at(r + 4,  "t1_wait_entry", 0, 1, 0, 0, 0);
    expect_at(m + 10, "t1_pre_release", 0, 1, 0, 0, 0);
    expect_at(m + 11, "t1_release", 0, 0, 1, 0, 0);
    tick(m - cyc);
    pll_lock = 1'b1;

    // Scenario 4: lock loss in RUN.
    m2 = m + 15;
    tick(m2 - cyc);
    pll_lock = 1'b0;
    expect_at(m2 + 2, "t4_still_run", 0, 0, 1, 0, 0);
    expect_at(m2 + 3, "t4_loss", 1, 1, 0, 0, 0);
`ifdef PLL_LOSS_CNT_EN
    expect_llc(m2 + 3, "t4_llc", 8'd1);
`endif
    expect_at(m2 + 6, "t4_pulse_last", 1, 1, 0, 0, 0);
    expect_at(m2 + 7, "t4_wait", 0, 1, 0, 0, 0);

    // Scenario 3: one timeout (retry_cnt=1), then a glitch during STAB.
    b  = m2 + 7;
    w3 = b + 24;
    m3 = w3 + 2;
    m4 = m3 + 8;
    expect_at(b + 19,  "t3_wait_end", 0, 1, 0, 0, 0);
    expect_at(b + 20,  "t3_retry1", 1, 1, 0, 0, 1);
    expect_at(w3,      "t3_wait2", 0, 1, 0, 0, 1);
    expect_at(m3 + 7,  "t3_stab", 0, 1, 0, 0, 1);
    expect_at(m3 + 11, "t3_glitch_held", 0, 1, 0, 0, 1);
    expect_at(m4 + 10, "t3_pre_release", 0, 1, 0, 0, 1);
    expect_at(m4 + 11, "t3_release", 0, 0, 1, 0, 0);
    tick(m3 - cyc);
    pll_lock = 1'b1;
    tick(5);
    pll_lock = 1'b0;
    tick(3);
    pll_lock = 1'b1;
    tick(15);

    // Scenario 2: lock never arrives; three pulses then FAIL.
    do_reset("t2_reset_vals", r);
    expect_at(r + 3,  "t2_p1_last", 1, 1, 0, 0, 0);
    expect_at(r + 4,  "t2_w1", 0, 1, 0, 0, 0);
    expect_at(r + 23, "t2_w1_end", 0, 1, 0, 0, 0);
    expect_at(r + 24, "t2_p2", 1, 1, 0, 0, 1);
    expect_at(r + 27, "t2_p2_last", 1, 1, 0, 0, 1);
    expect_at(r + 28, "t2_w2", 0, 1, 0, 0, 1);
    expect_at(r + 47, "t2_w2_end", 0, 1, 0, 0, 1);
    expect_at(r + 48, "t2_p3", 1, 1, 0, 0, 2);
    expect_at(r + 51, "t2_p3_last", 1, 1, 0, 0, 2);
    expect_at(r + 52, "t2_w3", 0, 1, 0, 0, 2);
    expect_at(r + 71, "t2_w3_end", 0, 1, 0, 0, 2);
    expect_at(r + 72, "t2_fail", 1, 1, 0, 1, 2);
    expect_at(r + 92, "t2_fail_stuck", 1, 1, 0, 1, 2);
    tick(r + 92 - cyc);

    // Scenario 5: reset from FAIL, then reset during WAIT with retry_cnt=1.
    do_reset("t5_rst_from_fail", r2);
    expect_at(r2 + 24, "t5_retry1", 1, 1, 0, 0, 1);
    expect_at(r2 + 32, "t5_pre_rst", 0, 1, 0, 0, 1);
    tick(r2 + 32 - cyc);
    do_reset("t5_rst_in_wait", r3);
    expect_at(r3 + 4, "t5_wait_after", 0, 1, 0, 0, 0);
    tick(5);

`ifdef PLL_LOSS_CNT_EN
    // Scenario 6: saturate the loss counter.
    pll_lock = 1'b1;
    tick(15);
    expect_at(cyc + 1, "t6_run", 0, 0, 1, 0, 0);
    expect_llc(cyc + 1, "t6_llc0", 8'd0);
    for (int i = 1; i <= 260; i++) begin
      pll_lock = 1'b0;
      tick(4);
      pll_lock = 1'b1;
      tick(20);
      if (i == 1 || i == 2 || i == 254 || i == 255 || i == 256 || i == 260) begin
        expect_at(cyc + 1, $sformatf("t6_run_%0d", i), 0, 0, 1, 0, 0);
        expect_llc(cyc + 1, $sformatf("t6_llc_%0d", i), (i > 255) ? 8'd255 : 8'(i));
      end
    end
`endif

    tick(5);
    while (q.size() > 0) begin
      mon_e = q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s: expected check at cycle %0d never evaluated", mon_e.nm, mon_e.cyc);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
